// File: rtl/dijkstra_pkg.sv
// dijkstra_pkg
// Constants and types shared by the Dijkstra solver and its downstream path
// consumers.
//   NODE_W      bits per node ID
//   MAX_HOPS    slots in the packed final_path vector
//   NODE_COUNT  valid node IDs are 0..NODE_COUNT-1
//   EMPTY_CODE  sentinel marking an unused slot
//   state_t     path streamer FSM encoding
//   slot_at()   extracts slot i from a packed path vector
package dijkstra_pkg;

   localparam int NODE_W     = 5;
   localparam int MAX_HOPS   = 10;
   localparam int NODE_COUNT = 19;
   localparam int HOP_IDX_W  = 4;
   localparam int PATH_W     = MAX_HOPS * NODE_W;

   localparam logic [NODE_W-1:0] EMPTY_CODE    = NODE_W'(31);
   localparam logic [NODE_W-1:0] NODE_ID_LIMIT = NODE_W'(NODE_COUNT);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   function automatic logic [NODE_W-1:0] slot_at(input logic [PATH_W-1:0] path,
                                                 input int i);
      return path[i*NODE_W +: NODE_W];
   endfunction

endpackage

// File: rtl/dijkstra_path_streamer_if.sv
// dijkstra_path_streamer_if
// Hop stream from the path streamer to its consumer.
// Handshake: a hop transfers on a rising clk edge where hop_valid && hop_ready.
// While hop_valid is high and hop_ready is low, hop_node/hop_index/hop_last
// hold stable and hop_valid stays high until the transfer happens.
//   hop_valid  hop fields are valid
//   hop_ready  consumer accepts the hop
//   hop_node   node ID of this hop
//   hop_index  0-based position of the hop in the path
//   hop_last   final hop of the path
interface dijkstra_path_streamer_if;
   import dijkstra_pkg::*;

   logic                 hop_valid;
   logic                 hop_ready;
   logic [NODE_W-1:0]    hop_node;
   logic [HOP_IDX_W-1:0] hop_index;
   logic                 hop_last;

   modport master (output hop_valid, hop_node, hop_index, hop_last,
                   input  hop_ready);
   modport slave  (input  hop_valid, hop_node, hop_index, hop_last,
                   output hop_ready);
endinterface

// File: rtl/path_len_scan.sv
// path_len_scan
// Combinational priority scan over a packed path vector. Counts the leading
// slots (from slot 0) holding a valid node ID; the scan stops at the first
// slot that is EMPTY_CODE or an out-of-range ID.
//   final_path  packed path, slot i at [i*NODE_W +: NODE_W]
//   path_len    number of leading valid slots (0..MAX_HOPS)
//   err_node    the stopping slot held an out-of-range ID (not the sentinel)
module path_len_scan
   import dijkstra_pkg::*;
(
   input  logic [PATH_W-1:0]    final_path,
   output logic [HOP_IDX_W-1:0] path_len,
   output logic                 err_node
);

   logic              stop;
   logic [NODE_W-1:0] slot;

   always_comb begin
      path_len = '0;
      err_node = 1'b0;
      stop     = 1'b0;
      slot     = '0;
      for (int i = 0; i < MAX_HOPS; i++) begin
         slot = slot_at(final_path, i);
         if (!stop) begin
            if (slot == EMPTY_CODE) begin
               stop = 1'b1;
            end else if (slot >= NODE_ID_LIMIT) begin
               stop     = 1'b1;
               err_node = 1'b1;
            end else begin
               path_len = path_len + 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/dijkstra_path_streamer.sv
// dijkstra_path_streamer
// On a rising edge of path_done, captures the solver's packed final_path and
// clock_cycles, then replays the valid prefix of the path one hop at a time.
//   clk, reset    clock; synchronous active-high reset
//   path_done     solver done level; only its rising edge triggers a capture
//   final_path    packed path, slot 0 = start node
//   clock_cycles  solver cycle count, captured with final_path
//   hop           hop stream (master side)
//   path_len      valid hops in the captured path
//   cycles_out    captured clock_cycles
//   stream_done   one-cycle pulse when the stream completes
//   busy          high outside IDLE
//   err_node      sticky: scan stopped on an out-of-range ID
//   overrun       sticky: a trigger arrived while busy (result dropped)
//   state_dbg     current FSM state
module dijkstra_path_streamer
   import dijkstra_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     path_done,
   input  logic [PATH_W-1:0]        final_path,
   input  logic [31:0]              clock_cycles,
   dijkstra_path_streamer_if.master hop,
   output logic [HOP_IDX_W-1:0]     path_len,
   output logic [31:0]              cycles_out,
   output logic                     stream_done,
   output logic                     busy,
   output logic                     err_node,
   output logic                     overrun,
   output state_t                   state_dbg
);

   state_t               state, state_next;
   logic                 path_done_q;
   logic [PATH_W-1:0]    slots;
   logic [HOP_IDX_W-1:0] idx;
   logic [HOP_IDX_W-1:0] scan_len;
   logic                 scan_err;
   logic                 trigger;
   logic                 last_hop;
   logic                 xfer;

   path_len_scan u_scan (
      .final_path (final_path),
      .path_len   (scan_len),
      .err_node   (scan_err)
   );

   assign trigger  = path_done && !path_done_q;
   assign last_hop = (idx == path_len - 4'd1);
   assign xfer     = hop.hop_valid && hop.hop_ready;

   always_comb begin
      state_next    = state;
      hop.hop_valid = 1'b0;
      stream_done   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (trigger) state_next = ST_STREAM;
         end
         ST_STREAM: begin
            // An empty path presents nothing and finishes straight away.
            hop.hop_valid = (path_len != 4'd0);
            if (path_len == 4'd0)
               state_next = ST_FINISH;
            else if (hop.hop_ready && last_hop)
               state_next = ST_FINISH;
         end
         ST_FINISH: begin
            stream_done = 1'b1;
            state_next  = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign hop.hop_node  = slot_at(slots, int'(idx));
   assign hop.hop_index = idx;
   assign hop.hop_last  = last_hop;
   assign busy          = (state != ST_IDLE);
   assign state_dbg     = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         path_done_q <= 1'b0;
         slots       <= '0;
         idx         <= '0;
         path_len    <= '0;
         cycles_out  <= '0;
         err_node    <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state       <= state_next;
         path_done_q <= path_done;
         if (trigger && state == ST_IDLE) begin
            slots      <= final_path;
            cycles_out <= clock_cycles;
            path_len   <= scan_len;
            idx        <= '0;
            if (scan_err) err_node <= 1'b1;
         end
         // FINISH counts as busy: a result arriving there is dropped too.
         if (trigger && state != ST_IDLE) overrun <= 1'b1;
         // Index parks on the last hop so a full path never wraps.
         if (xfer && !last_hop) idx <= idx + 4'd1;
      end
   end

endmodule

// File: doc/dijkstra_path_streamer.md
Name: dijkstra_path_streamer

Overview:
Downstream stage of the Dijkstra solver. On each new result it captures the packed final_path vector (10 slots x 5 bits) and replays it as a stream of hop nodes over a valid/ready handshake. Each hop carries its index and a last flag, so the consumer never has to unpack the vector. Also reports path length, the solver cycle count and error flags for the result.

Parameters:
NODE_W, 5, bits per node ID (matches s_node/e_node width)
MAX_HOPS, 10, slots in final_path
NODE_COUNT, 19, valid node IDs are 0..NODE_COUNT-1
EMPTY_CODE, 31, sentinel marking an unused slot

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
path_done  input  1  solver done (level; held high until solver reset)
final_path  input  MAX_HOPS*NODE_W  slot i at bits [i*NODE_W +: NODE_W]; slot 0 = start node
clock_cycles  input  32  solver cycle count, sampled with final_path
hop_valid  output  1  hop_node/hop_index/hop_last valid
hop_ready  input  1  consumer accepts the hop
hop_node  output  NODE_W  current node ID
hop_index  output  4  position of the hop in the path, 0-based
hop_last  output  1  final hop of the path
path_len  output  4  number of valid hops in the captured path (0..MAX_HOPS)
cycles_out  output  32  captured clock_cycles
stream_done  output  1  one-cycle pulse when the stream completes
busy  output  1  high outside IDLE
err_node  output  1  sticky; a non-sentinel slot held an ID >= NODE_COUNT
overrun  output  1  sticky; a path_done rising edge arrived while busy

Behaviour:
- Reset (synchronous, active-high) clears all outputs and the path_done edge-detect register. State returns to IDLE. Reset mid-stream abandons the stream with no stream_done pulse.
- Trigger: a rising edge of path_done (registered previous value). A held-high level never retriggers.
- States and transitions:
  - IDLE -> STREAM on a trigger.
  - STREAM -> FINISH after the last hop is accepted.
  - FINISH -> IDLE unconditionally. stream_done = 1 only in FINISH.
- Capture (clock edge k, trigger seen in IDLE):
  - Latch final_path into a slot register and clock_cycles into cycles_out.
  - path_len = count of leading slots, from slot 0, that are neither EMPTY_CODE nor >= NODE_COUNT. The scan stops at the first such slot.
  - Set err_node if the stopping slot is not EMPTY_CODE.
- Slots after the first sentinel are ignored, even if they hold valid IDs.
- Latency: hop 0 is presented (hop_valid = 1) in the cycle after edge k.
- path_len = 0: no hop is presented. Go STREAM -> FINISH directly, so stream_done pulses at edge k+2.
- Handshake:
  - A hop transfers on an edge where hop_valid && hop_ready.
  - hop_node/hop_index/hop_last hold stable while hop_valid && !hop_ready.
  - hop_valid never drops without a transfer.
  - hop_index increments by 1 per transfer.
  - hop_last = (hop_index == path_len-1).
  - Back-to-back transfers run one hop per cycle when hop_ready is held high.
- Full path: path_len = MAX_HOPS is legal. hop_index reaches 9, and the counter must not wrap past MAX_HOPS-1.
- Trigger while busy: overrun is set and the new result is dropped. The current stream is unaffected.
- Trigger in the FINISH cycle counts as busy.
- err_node and overrun clear only on reset.
- path_len and cycles_out hold their values until the next capture.

Decomposition:
- Shared package dijkstra_pkg holds NODE_W, MAX_HOPS, NODE_COUNT, EMPTY_CODE, the state encoding, and the slot-extract function. The solver uses the same constants.
- One sub-module, path_len_scan: combinational priority scan that returns path_len and the error flag from final_path. It is reused by any future path consumer.

Test Plan:
1. Path 0->2->7->11 (slots 0,2,7,11, rest 31), hop_ready = 1, clock_cycles = 57.
   - Required: hops 0,2,7,11 on consecutive cycles with indices 0..3; hop_last only on 11.
   - Required: path_len = 4, cycles_out = 57, stream_done pulses one cycle after the last transfer.
2. Same path, hop_ready toggled 1,0,0,1,0,1,...
   - Required: hop_node stays stable through each stall; no hop is lost or duplicated; order unchanged.
3. Slot 0 = 31 (empty path).
   - Required: hop_valid never asserts, path_len = 0, stream_done at edge k+2.
4. All 10 slots valid (0..9).
   - Required: 10 transfers, hop_last on index 9, no wrap.
   - Then slots 0,3,25,4: required path_len = 2, hops 0,3 only, err_node = 1.
5. Second path_done rising edge during a stalled stream.
   - Required: overrun = 1, original stream completes intact.
   - Then path_done held high for 20 cycles: required no retrigger.
6. Reset asserted mid-stream after 2 transfers.
   - Required: next cycle hop_valid = 0, busy = 0, flags cleared, no stream_done pulse.
   - A new trigger afterwards streams normally from index 0.
